// File: rtl/aes128.sv
// Fully pipelined AES-128 encrypt core: one block per clock, ciphertext 10 cycles after sampling.
// Optional valid tracking (in_valid/out_valid) is enabled by defining AES128_VALID_EN.
module aes128 (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
`ifdef AES128_VALID_EN
  ,
  input  logic         in_valid,
  output logic         out_valid
`endif
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the block is column i/4, row i%4; ShiftRows pulls row r from column c+r.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                            input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        a[rr + 4*c] = sbox(s[127 - 8*(rr + 4*((c + rr) & 3)) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        b[4*c]     = xtime(a[4*c]) ^ xtime(a[4*c+1]) ^ a[4*c+1] ^ a[4*c+2] ^ a[4*c+3];
        b[4*c + 1] = a[4*c] ^ xtime(a[4*c+1]) ^ xtime(a[4*c+2]) ^ a[4*c+2] ^ a[4*c+3];
        b[4*c + 2] = a[4*c] ^ a[4*c+1] ^ xtime(a[4*c+2]) ^ xtime(a[4*c+3]) ^ a[4*c+3];
        b[4*c + 3] = xtime(a[4*c]) ^ a[4*c] ^ a[4*c+1] ^ a[4*c+2] ^ xtime(a[4*c+3]);
      end else begin
        b[4*c]     = a[4*c];
        b[4*c + 1] = a[4*c+1];
        b[4*c + 2] = a[4*c+2];
        b[4*c + 3] = a[4*c+3];
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = b[i];
    end
    return r ^ rk;
  endfunction

  logic [127:0] s_q  [0:10];
  logic [127:0] s_d  [0:10];
  logic [127:0] k_q  [0:9];
  logic [127:0] rk_d [1:10];

  assign s_d[0] = state ^ key;

  // The round key for stage gi is derived combinationally from the previous stage's key.
  for (genvar gi = 1; gi <= 10; gi++) begin : g_round
    assign rk_d[gi] = key_expand(k_q[gi-1], RCON[87 - 8*gi -: 8]);
    assign s_d[gi]  = round_fn(s_q[gi-1], rk_d[gi], (gi < 10) ? 1'b1 : 1'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) s_q[i] <= '0;
      for (int i = 0; i <= 9; i++) k_q[i] <= '0;
    end else begin
      for (int i = 0; i <= 10; i++) s_q[i] <= s_d[i];
      k_q[0] <= key;
      for (int i = 1; i <= 9; i++) k_q[i] <= rk_d[i];
    end
  end

  assign out = s_q[10];

`ifdef AES128_VALID_EN
  logic [10:0] v_q;
  logic [10:0] v_d;

  assign v_d = {v_q[9:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  assign out_valid = v_q[10];
`endif

endmodule

// File: tb/tb_aes128.sv
// Bench for aes128: FIPS-197 known answers plus random blocks against a byte-level AES model.
// Honours AES128_VALID_EN when defined.
module tb_aes128;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic         in_v;
`ifdef AES128_VALID_EN
  logic         out_valid;
`endif

  aes128 dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .key   (key),
    .out   (out)
`ifdef AES128_VALID_EN
    ,
    .in_valid  (in_v),
    .out_valid (out_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  bit [7:0]     sb [256];
  bit           rst_h  [0:1023];
  bit           samp_v [0:1023];
  logic [127:0] exp_h  [0:1023];
  bit           kat_h  [0:1023];
  logic [127:0] kat_v  [0:1023];

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  function automatic bit [7:0] gmul(input bit [7:0] a_in, input bit [7:0] b_in);
    bit [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl8(input bit [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from the multiplicative inverse and affine map, not from a table.
  function automatic void build_sbox();
    bit [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
    bit [31:0]  w [44];
    bit [31:0]  t;
    bit [7:0]   rc;
    bit [7:0]   st [16];
    bit [7:0]   tmp [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            tmp[r + 4*c] = sb[st[r + 4*((c + r) % 4)]];
        for (int c = 0; c < 4; c++) begin
          if (rd < 10) begin
            st[4*c]   = gmul(tmp[4*c], 2) ^ gmul(tmp[4*c+1], 3) ^ tmp[4*c+2] ^ tmp[4*c+3];
            st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 2) ^ gmul(tmp[4*c+2], 3) ^ tmp[4*c+3];
            st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 2) ^ gmul(tmp[4*c+3], 3);
            st[4*c+3] = gmul(tmp[4*c], 3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 2);
          end else begin
            for (int r = 0; r < 4; r++) st[4*c + r] = tmp[4*c + r];
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r + 4*c] = st[r + 4*c] ^ w[4*rd + c][31 - 8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive inputs, let the edge happen, then check what that edge produced.
  task automatic step(input bit r, input bit v, input logic [127:0] pt, input logic [127:0] k,
                      input bit has_kat, input logic [127:0] kv);
    bit window_ok;
    bit exp_ov;
    rst   = r;
    in_v  = v;
    state = pt;
    key   = k;
    rst_h[edge_n]  = r;
    samp_v[edge_n] = v;
    exp_h[edge_n]  = ref_enc(pt, k);
    kat_h[edge_n]  = has_kat;
    kat_v[edge_n]  = kv;
    @(posedge clk);
    #1;
    window_ok = (edge_n >= 10);
    if (window_ok) begin
      for (int j = edge_n - 10; j <= edge_n; j++) if (rst_h[j]) window_ok = 1'b0;
    end
    exp_ov = window_ok ? samp_v[edge_n - 10] : 1'b0;
    if (r) begin
      checks++;
      assert (out === 128'h0) else begin
        failures++;
        $error("FAIL reset_out edge=%0d got=%h expected=%h", edge_n, out, 128'h0);
      end
    end else if (window_ok) begin
      checks++;
      assert (out === exp_h[edge_n - 10]) else begin
        failures++;
        $error("FAIL cipher edge=%0d got=%h expected=%h", edge_n, out, exp_h[edge_n - 10]);
      end
      if (kat_h[edge_n - 10]) begin
        checks++;
        assert (out === kat_v[edge_n - 10]) else begin
          failures++;
          $error("FAIL kat edge=%0d got=%h expected=%h", edge_n, out, kat_v[edge_n - 10]);
        end
      end
    end
`ifdef AES128_VALID_EN
    checks++;
    assert (out_valid === exp_ov) else begin
      failures++;
      $error("FAIL out_valid edge=%0d got=%b expected=%b", edge_n, out_valid, exp_ov);
    end
`endif
    $display("edge=%0d rst=%0b in_v=%0b out=%h", edge_n, r, v, out);
    edge_n++;
  endtask

  initial begin
    rst = 1'b1; in_v = 1'b0; state = '0; key = '0;
    build_sbox();

    // Two reset cycles, then the C.1 vector alone.
    step(1'b1, 1'b0, rnd128(), rnd128(), 1'b0, '0);
    step(1'b1, 1'b0, rnd128(), rnd128(), 1'b0, '0);
    step(1'b0, 1'b1, C1_P, C1_K, 1'b1, C1_C);
    repeat (9) step(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, '0);
    step(1'b0, 1'b1, B_P, B_K, 1'b1, B_C);

    // Back-to-back known answers.
    step(1'b0, 1'b1, C1_P, C1_K, 1'b1, C1_C);
    step(1'b0, 1'b1, B_P, B_K, 1'b1, B_C);
    step(1'b0, 1'b1, '0, '0, 1'b1, Z_C);

    repeat (20) step(1'b0, 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'b0, '0);

    // Block in flight when reset hits five cycles later.
    step(1'b0, 1'b1, B_P, B_K, 1'b1, B_C);
    repeat (4) step(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, '0);
    step(1'b1, 1'b1, rnd128(), rnd128(), 1'b0, '0);
    step(1'b0, 1'b1, C1_P, C1_K, 1'b1, C1_C);

    // Valid pattern 1,0,1.
    step(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, '0);
    step(1'b0, 1'b0, rnd128(), rnd128(), 1'b0, '0);
    step(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, '0);

    repeat (30) step(1'b0, 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'b0, '0);
    repeat (11) step(1'b0, 1'b0, rnd128(), rnd128(), 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
